// File: rtl/shared_ram_arbiter.sv
// Round-robin front end that lets CLIENTS requesters share one single-port synchronous
// RAM: one access per clock, byte-masked writes, registered read return, range checking.
module shared_ram_arbiter #(
  parameter int CLIENTS       = 2,
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DEPTH         = 65536
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic [CLIENTS-1:0]                  i_req,
  input  logic [CLIENTS-1:0]                  i_write,
  input  logic [CLIENTS*ADDRESS_WIDTH-1:0]    i_address,
  input  logic [CLIENTS*(WORD_WIDTH/8)-1:0]   i_byte_enable,
  input  logic [CLIENTS*WORD_WIDTH-1:0]       i_in_data,
  output logic [CLIENTS-1:0]                  o_grant,
  output logic [WORD_WIDTH-1:0]               o_out_data,
  output logic [CLIENTS-1:0]                  o_out_valid,
  output logic                                o_error
);

  localparam int BYTES = WORD_WIDTH / 8;
  localparam int LW    = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1   = ADDRESS_WIDTH + 1;
  // One extra bit so DEPTH == 2**ADDRESS_WIDTH is representable and never flags
  localparam logic [ADDRESS_WIDTH:0] DEPTH_L  = AW1'(DEPTH);
  localparam logic [LW-1:0]          LAST_RST = LW'(CLIENTS - 1);

  logic [WORD_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic [LW-1:0]            r_last;
  logic [WORD_WIDTH-1:0]    r_out_data;
  logic [CLIENTS-1:0]       r_out_valid;
  logic                     r_error;

  logic [LW-1:0]            w_sel;
  logic [LW-1:0]            w_cand;
  logic                     w_any;
  logic                     w_live;
  logic                     w_write;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [BYTES-1:0]         w_be;
  logic [WORD_WIDTH-1:0]    w_wdata;
  logic                     w_in_range;
  logic [IW-1:0]            w_idx;

  // First requester scanning upward from the client after the last one served
  always_comb begin
    w_sel  = r_last;
    w_cand = '0;
    w_any  = 1'b0;
    for (int k = 1; k <= CLIENTS; k++) begin
      w_cand = LW'((int'(r_last) + k) % CLIENTS);
      if (!w_any && i_req[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  assign w_live = w_any & ~i_reset;

  generate
    for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_grant
      assign o_grant[gi] = w_live && (w_sel == LW'(gi));
    end
  endgenerate

  assign w_write    = i_write[w_sel];
  assign w_addr     = i_address[int'(w_sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign w_be       = i_byte_enable[int'(w_sel)*BYTES +: BYTES];
  assign w_wdata    = i_in_data[int'(w_sel)*WORD_WIDTH +: WORD_WIDTH];
  assign w_in_range = {1'b0, w_addr} < DEPTH_L;
  assign w_idx      = w_addr[IW-1:0];

  always_ff @(posedge i_clock) begin
    if (w_live && w_write && w_in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last      <= LAST_RST;
      r_out_data  <= '0;
      r_out_valid <= '0;
      r_error     <= 1'b0;
    end else begin
      r_out_valid <= '0;
      r_error     <= 1'b0;
      if (w_any) begin
        r_last  <= w_sel;
        r_error <= ~w_in_range;
        if (!w_write) begin
          r_out_valid <= o_grant;
          r_out_data  <= w_in_range ? r_mem[w_idx] : '0;
        end
      end
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_error     = r_error;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Bench for shared_ram_arbiter: directed scenarios plus a randomized run, all checked
// against a transaction-level model of the arbitration rule and the RAM contents.
module tb_shared_ram_arbiter;
  localparam int C  = 3;
  localparam int AW = 16;
  localparam int WW = 32;
  localparam int BY = WW / 8;
  localparam int D  = 1024;

  logic            clk = 1'b0;
  logic            rst;
  logic [C-1:0]    req, wr;
  logic [C*AW-1:0] addr;
  logic [C*BY-1:0] be;
  logic [C*WW-1:0] wdata;
  logic [C-1:0]    grant, oval;
  logic [WW-1:0]   odata;
  logic            oerr;

  always #5 clk = ~clk;

  shared_ram_arbiter #(
    .CLIENTS(C), .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .DEPTH(D)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_write(wr), .i_address(addr),
    .i_byte_enable(be), .i_in_data(wdata), .o_grant(grant), .o_out_data(odata),
    .o_out_valid(oval), .o_error(oerr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pointer, word store with per-byte "written" flags, expected outputs
  int              m_last;
  int              m_gidx;
  logic [WW-1:0]   m_mem [D];
  logic [BY-1:0]   m_def [D];
  logic [C-1:0]    e_valid;
  logic [WW-1:0]   e_data, e_mask;
  logic            e_error;

  function automatic logic [C-1:0] exp_grant();
    if (rst) return '0;
    for (int k = 1; k <= C; k++) begin
      if (req[(m_last + k) % C]) return C'(1 << ((m_last + k) % C));
    end
    return '0;
  endfunction

  task automatic set_client(int c, bit r, bit w, int a, logic [BY-1:0] m, logic [WW-1:0] d);
    req[c] = r;
    wr[c]  = w;
    addr[c*AW +: AW]  = AW'(a);
    be[c*BY +: BY]    = m;
    wdata[c*WW +: WW] = d;
  endtask

  // Advance one clock edge and apply the same edge to the model
  task automatic tick();
    logic [C-1:0] eg;
    int g, a;
    @(posedge clk);
    eg = exp_grant();
    g = -1;
    for (int i = 0; i < C; i++) if (eg[i]) g = i;
    m_gidx = g;
    if (rst) begin
      m_last = C - 1; e_valid = '0; e_error = 1'b0; e_data = '0; e_mask = '1;
    end else begin
      e_valid = '0;
      e_error = 1'b0;
      if (g >= 0) begin
        a = int'(addr[g*AW +: AW]);
        m_last = g;
        $display("txn client=%0d %s addr=%0d", g, wr[g] ? "write" : "read", a);
        if (a >= D) begin
          e_error = 1'b1;
          if (!wr[g]) begin e_valid = C'(1 << g); e_data = '0; e_mask = '1; end
        end else if (wr[g]) begin
          for (int b = 0; b < BY; b++) begin
            if (be[g*BY + b]) begin
              m_mem[a][b*8 +: 8] = wdata[g*WW + b*8 +: 8];
              m_def[a][b] = 1'b1;
            end
          end
        end else begin
          e_valid = C'(1 << g);
          e_data  = m_mem[a];
          for (int b = 0; b < BY; b++) e_mask[b*8 +: 8] = {8{m_def[a][b]}};
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; wr = '0; addr = '0; be = '0; wdata = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (grant !== '0) begin n_fail++; $display("FAIL reset_grant cyc%0d: got %b want 000", i, grant); end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (odata !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", odata); end
    n_checks++;
    if (oval !== '0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 000", oval); end
    n_checks++;
    if (oerr !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", oerr); end
    n_checks++;
    if (grant !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 001", grant); end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [C-1:0] pat [9];
    logic [C-1:0] exp [9];
    logic [C-1:0] prev;
    pat  = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101};
    exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
    prev = '0;
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < C; c++) set_client(c, pat[i][c], 1'b0, 100 + c, '0, '0);
      @(negedge clk);
      n_checks++;
      if (grant !== exp[i]) begin n_fail++; $display("FAIL rr_grant cyc%0d: got %b want %b", i, grant, exp[i]); end
      n_checks++;
      if (oval !== prev) begin n_fail++; $display("FAIL rr_out_valid cyc%0d: got %b want %b", i, oval, prev); end
      prev = exp[i];
      tick();
    end
    req = '0;
    @(negedge clk);
    n_checks++;
    if (oval !== 3'b001) begin n_fail++; $display("FAIL rr_last_valid: got %b want 001", oval); end
    tick();
  endtask

  task automatic test_byte_mask();
    set_client(0, 1'b1, 1'b1, 5, 4'hF, 32'hAABBCCDD);
    @(negedge clk);
    n_checks++;
    if (grant !== 3'b001) begin n_fail++; $display("FAIL bm_grant_w1: got %b want 001", grant); end
    tick();
    set_client(0, 1'b1, 1'b1, 5, 4'b0101, 32'h11223344);
    @(negedge clk);
    n_checks++;
    if (grant !== 3'b001) begin n_fail++; $display("FAIL bm_grant_w2: got %b want 001", grant); end
    n_checks++;
    if (oval !== '0) begin n_fail++; $display("FAIL bm_write_valid: got %b want 000", oval); end
    tick();
    set_client(0, 1'b1, 1'b0, 5, '0, '0);
    @(negedge clk);
    n_checks++;
    if (grant !== 3'b001) begin n_fail++; $display("FAIL bm_grant_rd: got %b want 001", grant); end
    tick();
    req = '0;
    @(negedge clk);
    n_checks++;
    if (oval !== 3'b001) begin n_fail++; $display("FAIL bm_read_valid: got %b want 001", oval); end
    n_checks++;
    if (odata !== 32'hAA22CC44) begin n_fail++; $display("FAIL bm_read_data: got %h want aa22cc44", odata); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] d [4];
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      set_client(1, 1'b1, 1'b1, i, 4'hF, d[i]);
      @(negedge clk);
      tick();
    end
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) set_client(1, 1'b1, 1'b0, i, '0, '0);
      else req = '0;
      @(negedge clk);
      if (i < 4) begin
        n_checks++;
        if (grant !== 3'b010) begin n_fail++; $display("FAIL b2b_grant rd%0d: got %b want 010", i, grant); end
      end
      if (i > 0) begin
        n_checks++;
        if (oval !== 3'b010) begin n_fail++; $display("FAIL b2b_valid rd%0d: got %b want 010", i - 1, oval); end
        n_checks++;
        if (odata !== d[i-1]) begin n_fail++; $display("FAIL b2b_data rd%0d: got %h want %h", i - 1, odata, d[i-1]); end
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (oval !== '0) begin n_fail++; $display("FAIL b2b_valid_drop: got %b want 000", oval); end
    n_checks++;
    if (odata !== d[3]) begin n_fail++; $display("FAIL b2b_data_hold: got %h want %h", odata, d[3]); end
    tick();
  endtask

  task automatic test_out_of_range();
    set_client(0, 1'b1, 1'b1, D, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    tick();
    set_client(0, 1'b1, 1'b0, 0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (oerr !== 1'b1) begin n_fail++; $display("FAIL oor_write_error: got %b want 1", oerr); end
    n_checks++;
    if (oval !== '0) begin n_fail++; $display("FAIL oor_write_valid: got %b want 000", oval); end
    tick();
    set_client(0, 1'b1, 1'b0, 2000, '0, '0);
    @(negedge clk);
    n_checks++;
    if (oerr !== 1'b0) begin n_fail++; $display("FAIL oor_inrange_error: got %b want 0", oerr); end
    n_checks++;
    if (odata !== m_mem[0]) begin n_fail++; $display("FAIL oor_addr0_kept: got %h want %h", odata, m_mem[0]); end
    tick();
    req = '0;
    @(negedge clk);
    n_checks++;
    if (oval !== 3'b001) begin n_fail++; $display("FAIL oor_read_valid: got %b want 001", oval); end
    n_checks++;
    if (odata !== '0) begin n_fail++; $display("FAIL oor_read_data: got %h want 0", odata); end
    n_checks++;
    if (oerr !== 1'b1) begin n_fail++; $display("FAIL oor_read_error: got %b want 1", oerr); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_client(2, 1'b1, 1'b0, 1, '0, '0);
    @(negedge clk);
    n_checks++;
    if (grant !== 3'b100) begin n_fail++; $display("FAIL rm_grant: got %b want 100", grant); end
    tick();
    rst = 1'b1; req = '1;
    @(negedge clk);
    n_checks++;
    if (oval !== 3'b100) begin n_fail++; $display("FAIL rm_valid_in_reset: got %b want 100", oval); end
    n_checks++;
    if (grant !== '0) begin n_fail++; $display("FAIL rm_grant_in_reset: got %b want 000", grant); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (oval !== '0) begin n_fail++; $display("FAIL rm_valid_after: got %b want 000", oval); end
    n_checks++;
    if (odata !== '0 || oerr !== 1'b0) begin n_fail++; $display("FAIL rm_outputs_after: got data=%h err=%b want 0/0", odata, oerr); end
    n_checks++;
    if (grant !== 3'b001) begin n_fail++; $display("FAIL rm_pointer: got %b want 001", grant); end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    bit pend [C];
    int r, a;
    for (int c = 0; c < C; c++) pend[c] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < C; c++) begin
        if (pend[c] && $urandom_range(0, 19) == 0) begin
          pend[c] = 1'b0;
          req[c]  = 1'b0;
        end else if (!pend[c] && $urandom_range(0, 2) != 0) begin
          r = int'($urandom_range(0, 19));
          if (r < 17)       a = int'($urandom_range(0, 31));
          else if (r == 17) a = int'($urandom_range(D - 4, D - 1));
          else              a = int'($urandom_range(D, D + 7));
          pend[c] = 1'b1;
          set_client(c, 1'b1, 1'($urandom_range(0, 1)), a, BY'($urandom), $urandom);
        end
      end
      @(negedge clk);
      n_checks++;
      if (grant !== exp_grant()) begin n_fail++; $display("FAIL rnd_grant cyc%0d: got %b want %b", cyc, grant, exp_grant()); end
      n_checks++;
      if (oval !== e_valid) begin n_fail++; $display("FAIL rnd_valid cyc%0d: got %b want %b", cyc, oval, e_valid); end
      n_checks++;
      if (oerr !== e_error) begin n_fail++; $display("FAIL rnd_error cyc%0d: got %b want %b", cyc, oerr, e_error); end
      n_checks++;
      if ((odata & e_mask) !== (e_data & e_mask)) begin
        n_fail++; $display("FAIL rnd_data cyc%0d: got %h want %h (mask %h)", cyc, odata, e_data, e_mask);
      end
      tick();
      if (m_gidx >= 0) begin
        pend[m_gidx] = 1'b0;
        req[m_gidx]  = 1'b0;
      end
    end
    req = '0;
  endtask

  initial begin
    for (int i = 0; i < D; i++) m_def[i] = '0;
    m_last = C - 1; m_gidx = -1;
    e_valid = '0; e_error = 1'b0; e_data = '0; e_mask = '1;
    test_reset();
    test_round_robin();
    test_byte_mask();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
